// File: rtl/user_rq_pkt_fifo.sv
// Store-and-forward packet FIFO on the RQ AXI-S path: a TLP is released to the core only once fully buffered.
// Optional statistics counters are enabled by defining USER_RQ_PKT_FIFO_STATS_EN.
module user_rq_pkt_fifo #(
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int AXI4_RQ_TUSER_WIDTH = 62,
  parameter int DEPTH               = 32,
  parameter int LEVEL_W             = $clog2(DEPTH) + 1
) (
  input  logic                           user_clk,
  input  logic                           user_reset_n,
  input  logic [C_DATA_WIDTH-1:0]        in_tdata,
  input  logic [KEEP_WIDTH-1:0]          in_tkeep,
  input  logic [AXI4_RQ_TUSER_WIDTH-1:0] in_tuser,
  input  logic                           in_tlast,
  input  logic                           in_tvalid,
  output logic                           in_tready,
  output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  output logic                           s_axis_rq_tlast,
  output logic                           s_axis_rq_tvalid,
  input  logic                           s_axis_rq_tready,
  output logic [LEVEL_W-1:0]             fifo_level,
  output logic                           pkt_oversize
`ifdef USER_RQ_PKT_FIFO_STATS_EN
  ,
  output logic [31:0]                    stat_pkts_fwd,
  output logic [31:0]                    stat_stall_cycles
`endif
);

  localparam int AW = LEVEL_W - 1;
  localparam int KW = KEEP_WIDTH;
  localparam int UW = AXI4_RQ_TUSER_WIDTH;
  localparam int EW = C_DATA_WIDTH + KW + UW + 1;
  localparam logic [LEVEL_W-1:0] LVL_ZERO = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W-1:0] LVL_ONE  = {{(LEVEL_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CUT  = 2'd2
  } state_t;

  logic [EW-1:0]      mem_q [DEPTH];
  logic [LEVEL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               rdy_q, rdy_d;
  state_t             state_q;
  logic               oversize_q;

  logic               push_s;
  logic               pop_s;
  logic               tvalid_s;
  logic [EW-1:0]      head_s;
  logic               head_last_s;

  assign push_s      = in_tvalid & rdy_q;
  assign head_s      = mem_q[rd_ptr_q[AW-1:0]];
  assign head_last_s = head_s[0];
  assign tvalid_s    = ((state_q == ST_SEND) | (state_q == ST_CUT)) & ~empty_q;
  assign pop_s       = tvalid_s & s_axis_rq_tready;

  // Next-state for pointers, occupancy, complete-packet count and flags.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + LVL_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + LVL_ONE) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    case ({push_s & in_tlast, pop_s & head_last_s})
      2'b10:   pkt_cnt_d = pkt_cnt_q + LVL_ONE;
      2'b01:   pkt_cnt_d = pkt_cnt_q - LVL_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
    // Ready comes from a flop so core back-pressure never reaches the encoder combinationally.
    rdy_d   = ~full_d;
  end

  // Beat storage; contents need no reset because every read is qualified by the empty flag.
  always_ff @(posedge user_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_tdata, in_tkeep, in_tuser, in_tlast};
    end
  end

  // Pointer, level, packet-count and flag registers.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      wr_ptr_q  <= LVL_ZERO;
      rd_ptr_q  <= LVL_ZERO;
      level_q   <= LVL_ZERO;
      pkt_cnt_q <= LVL_ZERO;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rdy_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      rdy_q     <= rdy_d;
    end
  end

  // Output FSM: SEND forwards whole packets, CUT drains a TLP that can never fit.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q    <= ST_IDLE;
      oversize_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pkt_cnt_q != LVL_ZERO) begin
            state_q <= ST_SEND;
          end else if (full_q) begin
            state_q    <= ST_CUT;
            oversize_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (pop_s && head_last_s && (pkt_cnt_d == LVL_ZERO)) begin
            state_q <= ST_IDLE;
          end
        end
        ST_CUT: begin
          if (pop_s && head_last_s) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_tready        = rdy_q;
  assign s_axis_rq_tvalid = tvalid_s;
  assign s_axis_rq_tdata  = empty_q ? {C_DATA_WIDTH{1'b0}} : head_s[EW-1 -: C_DATA_WIDTH];
  assign s_axis_rq_tkeep  = empty_q ? {KW{1'b0}}           : head_s[UW+1 +: KW];
  assign s_axis_rq_tuser  = empty_q ? {UW{1'b0}}           : head_s[1 +: UW];
  assign s_axis_rq_tlast  = head_last_s & ~empty_q;
  assign fifo_level       = level_q;
  assign pkt_oversize     = oversize_q;

`ifdef USER_RQ_PKT_FIFO_STATS_EN
  logic [31:0] pkts_fwd_q;
  logic [31:0] stall_q;

  // Forwarded-packet counter wraps; stall counter saturates.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      pkts_fwd_q <= 32'd0;
      stall_q    <= 32'd0;
    end else begin
      if (pop_s && head_last_s) begin
        pkts_fwd_q <= pkts_fwd_q + 32'd1;
      end
      if (tvalid_s && !s_axis_rq_tready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_pkts_fwd     = pkts_fwd_q;
  assign stat_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_user_rq_pkt_fifo.sv
// Randomized bench for user_rq_pkt_fifo against a queue-based packet model, plus directed scenarios.
module tb_user_rq_pkt_fifo;

  localparam int DW    = 128;
  localparam int KW    = 4;
  localparam int UW    = 62;
  localparam int DEPTH = 32;
  localparam int LW    = 6;

  localparam int M_IDLE = 0;
  localparam int M_SEND = 1;
  localparam int M_CUT  = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_tdata;
  logic [KW-1:0] in_tkeep;
  logic [UW-1:0] in_tuser;
  logic          in_tlast;
  logic          in_tvalid;
  logic          in_tready;
  logic [DW-1:0] s_axis_rq_tdata;
  logic [KW-1:0] s_axis_rq_tkeep;
  logic [UW-1:0] s_axis_rq_tuser;
  logic          s_axis_rq_tlast;
  logic          s_axis_rq_tvalid;
  logic          s_axis_rq_tready;
  logic [LW-1:0] fifo_level;
  logic          pkt_oversize;

  user_rq_pkt_fifo #(
    .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .AXI4_RQ_TUSER_WIDTH(UW), .DEPTH(DEPTH), .LEVEL_W(LW)
  ) dut (
    .user_clk(clk), .user_reset_n(rst_n),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tuser(in_tuser), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .s_axis_rq_tdata(s_axis_rq_tdata), .s_axis_rq_tkeep(s_axis_rq_tkeep),
    .s_axis_rq_tuser(s_axis_rq_tuser), .s_axis_rq_tlast(s_axis_rq_tlast),
    .s_axis_rq_tvalid(s_axis_rq_tvalid), .s_axis_rq_tready(s_axis_rq_tready),
    .fifo_level(fifo_level), .pkt_oversize(pkt_oversize)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  beat_t mq[$];
  int    m_mode;
  bit    m_rdy;
  bit    m_ovs;
  int    n_pops = 0;
  bit    last_push;
  beat_t cb;
  int    seq = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int count_lasts();
    int c = 0;
    foreach (mq[i]) if (mq[i].l) c++;
    return c;
  endfunction

  function automatic bit exp_tvalid();
    return (m_mode != M_IDLE) && (mq.size() != 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = M_IDLE;
    m_rdy  = 1'b0;
    m_ovs  = 1'b0;
  endtask

  task automatic new_beat(input bit last);
    logic [63:0] t;
    t    = {$urandom(), $urandom()};
    cb.d = {$urandom(), $urandom(), $urandom(), seq};
    cb.k = t[63:60];
    cb.u = t[61:0] ^ {30'd0, $urandom()};
    cb.l = last;
    seq++;
  endtask

  task automatic drive(input bit v);
    in_tvalid = v;
    in_tdata  = cb.d;
    in_tkeep  = cb.k;
    in_tuser  = cb.u;
    in_tlast  = cb.l;
  endtask

  task automatic compare_all();
    chk("in_tready", in_tready, m_rdy);
    chk("tvalid", s_axis_rq_tvalid, exp_tvalid());
    chk("fifo_level", fifo_level, mq.size());
    chk("pkt_oversize", pkt_oversize, m_ovs);
    if (exp_tvalid()) begin
      chk("tdata", s_axis_rq_tdata, mq[0].d);
      chk("tkeep", s_axis_rq_tkeep, mq[0].k);
      chk("tuser", s_axis_rq_tuser, mq[0].u);
      chk("tlast", s_axis_rq_tlast, mq[0].l);
    end else if (mq.size() == 0) begin
      chk("tdata_empty", s_axis_rq_tdata, 0);
      chk("tlast_empty", s_axis_rq_tlast, 0);
    end
  endtask

  // One clock: decide handshakes from the model, advance it at the edge, compare on the falling edge.
  task automatic step();
    bit    push, pop, lp;
    int    pre_cnt;
    bit    pre_full;
    beat_t b;
    push = (rst_n === 1'b1) && (in_tvalid === 1'b1) && m_rdy;
    pop  = (rst_n === 1'b1) && exp_tvalid() && (s_axis_rq_tready === 1'b1);
    b.d = in_tdata; b.k = in_tkeep; b.u = in_tuser; b.l = in_tlast;
    @(posedge clk);
    last_push = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      pre_cnt  = count_lasts();
      pre_full = (mq.size() == DEPTH);
      lp       = 1'b0;
      if (pop) begin
        lp = mq[0].l;
        void'(mq.pop_front());
        n_pops++;
      end
      if (push) begin
        mq.push_back(b);
        last_push = 1'b1;
      end
      case (m_mode)
        M_IDLE: begin
          if (pre_cnt != 0) m_mode = M_SEND;
          else if (pre_full) begin m_mode = M_CUT; m_ovs = 1'b1; end
        end
        M_SEND: if (pop && lp && count_lasts() == 0) m_mode = M_IDLE;
        default: if (pop && lp) m_mode = M_IDLE;
      endcase
      m_rdy = (mq.size() != DEPTH);
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 2000000", $time);
    $fatal(1);
  end

  initial begin
    beat_t b1;
    int    i, k, cutc, p0, rem;
    bit    seen, have;

    rst_n = 1'b0;
    s_axis_rq_tready = 1'b0;
    cb = '{d: '0, k: '0, u: '0, l: 1'b0};
    drive(1'b0);
    model_reset();
    repeat (3) step();
    chk("rst_tready", in_tready, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_tvalid", s_axis_rq_tvalid, 0);
    rst_n = 1'b1;
    step();
    chk("tready_after_rst", in_tready, 1);

    // 1: two-beat TLP, latency and order
    s_axis_rq_tready = 1'b1;
    new_beat(1'b0); b1 = cb; drive(1'b1); step();
    new_beat(1'b1); drive(1'b1); step();
    drive(1'b0);
    chk("t1_level2", fifo_level, 2);
    chk("t1_tvalid_N", s_axis_rq_tvalid, 0);
    step();
    chk("t1_tvalid_N1", s_axis_rq_tvalid, 1);
    chk("t1_beat1_data", s_axis_rq_tdata, b1.d);
    chk("t1_beat1_last", s_axis_rq_tlast, 0);
    step();
    chk("t1_beat2_last", s_axis_rq_tlast, 1);
    chk("t1_level1", fifo_level, 1);
    step();
    chk("t1_done_tvalid", s_axis_rq_tvalid, 0);
    chk("t1_level0", fifo_level, 0);

    // 2: gap inside a TLP holds it back
    new_beat(1'b0); drive(1'b1); step();
    new_beat(1'b0); drive(1'b1); step();
    drive(1'b0);
    repeat (3) begin step(); chk("t2_gap_tvalid", s_axis_rq_tvalid, 0); end
    new_beat(1'b1); drive(1'b1); step();
    drive(1'b0);
    chk("t2_after_last_tvalid", s_axis_rq_tvalid, 0);
    repeat (3) begin step(); chk("t2_b2b_tvalid", s_axis_rq_tvalid, 1); end
    step();
    chk("t2_level0", fifo_level, 0);

    // 3: fill with 32 single-beat TLPs under back-pressure
    s_axis_rq_tready = 1'b0;
    for (int j = 0; j < 33; j++) begin new_beat(1'b1); drive(1'b1); step(); end
    chk("t3_tready_full", in_tready, 0);
    chk("t3_level_full", fifo_level, 32);
    drive(1'b0);
    s_axis_rq_tready = 1'b1;
    repeat (34) step();
    chk("t3_level_drained", fifo_level, 0);
    chk("t3_no_oversize", pkt_oversize, 0);

    // 4: steady concurrent push/pop
    s_axis_rq_tready = 1'b0;
    for (int j = 0; j < 4; j++) begin new_beat(1'b1); drive(1'b1); step(); end
    s_axis_rq_tready = 1'b1;
    for (int j = 0; j < 100; j++) begin
      new_beat(1'b1); drive(1'b1); step();
      chk("t4_level_const", fifo_level, 4);
    end
    drive(1'b0);
    repeat (6) step();
    chk("t4_level0", fifo_level, 0);

    // 5: 40-beat TLP through a 32-deep buffer
    s_axis_rq_tready = 1'b0;
    i = 0; k = 0; cutc = 0; seen = 1'b0; p0 = n_pops;
    new_beat(1'b0);
    while ((i < 40 || mq.size() != 0) && k < 600) begin
      if (m_mode == M_CUT) cutc++;
      s_axis_rq_tready = (cutc > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive(i < 40);
      step();
      k++;
      if (last_push) begin
        i++;
        if (i < 40) new_beat(i == 39);
      end
      if (m_ovs && !seen) begin
        seen = 1'b1;
        chk("t5_ovs_at_full", pkt_oversize, 1);
        chk("t5_level_full", fifo_level, 32);
      end
    end
    drive(1'b0);
    chk("t5_in_budget", k < 600, 1);
    chk("t5_beats_out", n_pops - p0, 40);
    chk("t5_idle_tvalid", s_axis_rq_tvalid, 0);
    s_axis_rq_tready = 1'b1;
    repeat (2) step();
    chk("t5_ovs_sticky", pkt_oversize, 1);

    // 6: reset mid-TLP
    s_axis_rq_tready = 1'b0;
    for (int j = 0; j < 5; j++) begin new_beat(1'b0); drive(1'b1); step(); end
    drive(1'b0);
    chk("t6_level5", fifo_level, 5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_tvalid", s_axis_rq_tvalid, 0);
    chk("t6_rst_ovs", pkt_oversize, 0);
    chk("t6_rst_tready", in_tready, 0);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    s_axis_rq_tready = 1'b1;
    p0 = n_pops;
    for (int j = 0; j < 3; j++) begin new_beat(j == 2); drive(1'b1); step(); end
    drive(1'b0);
    repeat (6) step();
    chk("t6_beats_out", n_pops - p0, 3);
    chk("t6_level0", fifo_level, 0);

    // random traffic
    rem = 0; have = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!have) begin
        if (rem == 0) rem = $urandom_range(1, 8);
        new_beat(rem == 1);
        have = 1'b1;
      end
      s_axis_rq_tready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0);
      step();
      if (last_push) begin have = 1'b0; rem--; end
    end
    drive(1'b0);
    s_axis_rq_tready = 1'b1;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
